// File: rtl/xillybus_rd_stream_mux.sv
// xillybus_rd_stream_mux
//   Merges NUM_CH user word streams onto one Xillybus host-read pipe. Each channel owns a
//   buffer FIFO; a round-robin arbiter copies framed bursts (header + payload) into a 4-deep
//   output FIFO that xillybus_core drains through the user_r_* interface.
//   Header word: {8'hA5, 4'h0, channel[3:0], payload_len[15:0]}.
//
//   Optional feature: define XILLY_MUX_CRC_EN to append a trailer word after each payload,
//   holding the modulo-2^32 sum of payload bits [31:0]. The header length excludes it.
//
// Ports
//   bus_clk      : clock
//   pcie_perstn  : async active-low reset, synchronous release expected
//   ch_data      : channel words, channel i at [i*DATA_W +: DATA_W]
//   ch_valid     : per-channel word valid
//   ch_ready     : per-channel FIFO not full
//   user_r_rden  : core read strobe
//   user_r_data  : read data, valid the cycle after an accepted rden
//   user_r_empty : output FIFO empty
//   user_r_eof   : tied to 0
//   user_r_open  : host file open; low aborts the burst and flushes the output FIFO
module xillybus_rd_stream_mux #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     bus_clk,
  input  logic                     pcie_perstn,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     user_r_rden,
  output logic [DATA_W-1:0]        user_r_data,
  output logic                     user_r_empty,
  output logic                     user_r_eof,
  input  logic                     user_r_open
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW  = FIFO_AW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
`ifdef XILLY_MUX_CRC_EN
    StData,
    StCrc
`else
    StData
`endif
  } state_e;

  // Channel FIFOs
  logic [DATA_W-1:0]                ch_mem [NUM_CH][Depth];
  logic [NUM_CH-1:0][FIFO_AW-1:0]   ch_wptr_q, ch_wptr_d, ch_rptr_q, ch_rptr_d;
  logic [NUM_CH-1:0][CntW-1:0]      ch_cnt_q, ch_cnt_d;
  logic [NUM_CH-1:0]                ch_push, ch_pop;
  logic [DATA_W-1:0]                ch_rd_word;

  // Output FIFO
  logic [DATA_W-1:0] out_mem [4];
  logic [1:0]        out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [2:0]        out_cnt_q, out_cnt_d;
  logic              out_full, out_wr, out_rd;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Arbiter / framer
  state_e            state_q, state_d;
  logic [ChW-1:0]    gnt_q, gnt_d, rr_q, rr_d;
  logic [CntW-1:0]   len_q, len_d, idx_q, idx_d;
  logic              pop_en;
  logic              found;
  logic [ChW-1:0]    sel, cand;
  logic [31:0]       hdr_word;
`ifdef XILLY_MUX_CRC_EN
  logic [31:0]       acc_q, acc_d;
`endif

  function automatic logic [ChW-1:0] wrap_idx(logic [ChW-1:0] base, int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NUM_CH;
    return s[ChW-1:0];
  endfunction

  assign ch_rd_word   = ch_mem[gnt_q][ch_rptr_q[gnt_q]];
  assign out_full     = (out_cnt_q == 3'd4);
  assign hdr_word     = {8'hA5, 4'h0, 4'(gnt_q), 16'(len_q)};
  assign user_r_data  = rdata_q;
  assign user_r_empty = (out_cnt_q == 3'd0);
  assign user_r_eof   = 1'b0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i]  = (ch_cnt_q[i] != CntW'(Depth));
      ch_push[i]   = ch_valid[i] && ch_ready[i];
      ch_pop[i]    = pop_en && (ChW'(i) == gnt_q);
      ch_wptr_d[i] = ch_wptr_q[i] + FIFO_AW'(ch_push[i]);
      ch_rptr_d[i] = ch_rptr_q[i] + FIFO_AW'(ch_pop[i]);
      ch_cnt_d[i]  = ch_cnt_q[i] + CntW'(ch_push[i]) - CntW'(ch_pop[i]);
    end
  end

  // Search order rr+1, rr+2, ... wrapping; iterate backwards so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = wrap_idx(rr_q, k);
      if (ch_cnt_q[cand] != '0) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    out_wr    = 1'b0;
    out_wdata = '0;
    pop_en    = 1'b0;
`ifdef XILLY_MUX_CRC_EN
    acc_d     = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (user_r_open && found) begin
          gnt_d   = sel;
          rr_d    = sel;
          len_d   = (ch_cnt_q[sel] > CntW'(MAX_BURST)) ? CntW'(MAX_BURST) : ch_cnt_q[sel];
          idx_d   = '0;
          state_d = StHdr;
`ifdef XILLY_MUX_CRC_EN
          acc_d   = '0;
`endif
        end
      end
      StHdr: begin
        if (!out_full) begin
          out_wr    = 1'b1;
          out_wdata = DATA_W'(hdr_word);
          state_d   = StData;
        end
      end
      StData: begin
        if (!out_full) begin
          out_wr    = 1'b1;
          out_wdata = ch_rd_word;
          pop_en    = 1'b1;
          idx_d     = idx_q + CntW'(1);
`ifdef XILLY_MUX_CRC_EN
          acc_d     = acc_q + ch_rd_word[31:0];
          if (idx_q == len_q - CntW'(1)) state_d = StCrc;
`else
          if (idx_q == len_q - CntW'(1)) state_d = StIdle;
`endif
        end
      end
`ifdef XILLY_MUX_CRC_EN
      StCrc: begin
        if (!out_full) begin
          out_wr    = 1'b1;
          out_wdata = DATA_W'(acc_q);
          state_d   = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Closing the file aborts: payload already copied out is dropped with the flush below.
    if (!user_r_open) begin
      state_d = StIdle;
      out_wr  = 1'b0;
      pop_en  = 1'b0;
    end
  end

  always_comb begin
    out_rd = user_r_open && user_r_rden && (out_cnt_q != 3'd0);
    if (!user_r_open) begin
      out_wptr_d = '0;
      out_rptr_d = '0;
      out_cnt_d  = '0;
    end else begin
      out_wptr_d = out_wptr_q + 2'(out_wr);
      out_rptr_d = out_rptr_q + 2'(out_rd);
      out_cnt_d  = out_cnt_q + 3'(out_wr) - 3'(out_rd);
    end
    rdata_d = out_rd ? out_mem[out_rptr_q] : rdata_q;
  end

  always_ff @(posedge bus_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_push[i]) ch_mem[i][ch_wptr_q[i]] <= ch_data[i*DATA_W +: DATA_W];
    end
    if (out_wr) out_mem[out_wptr_q] <= out_wdata;
  end

  always_ff @(posedge bus_clk or negedge pcie_perstn) begin
    if (!pcie_perstn) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rr_q       <= ChW'(NUM_CH - 1);
      len_q      <= '0;
      idx_q      <= '0;
      ch_wptr_q  <= '0;
      ch_rptr_q  <= '0;
      ch_cnt_q   <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
      rdata_q    <= '0;
`ifdef XILLY_MUX_CRC_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      ch_wptr_q  <= ch_wptr_d;
      ch_rptr_q  <= ch_rptr_d;
      ch_cnt_q   <= ch_cnt_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      rdata_q    <= rdata_d;
`ifdef XILLY_MUX_CRC_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_xillybus_rd_stream_mux.sv
// Bench for xillybus_rd_stream_mux (NUM_CH=4, DATA_W=32, FIFO_AW=4, MAX_BURST=8).
// Frames expected from the host side are queued as channel words are driven and checked
// as the core-side reads complete. Trailer words are expected when XILLY_MUX_CRC_EN is set.
module tb_xillybus_rd_stream_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ch_data = '0;
  logic [3:0]   ch_valid = '0;
  logic [3:0]   ch_ready;
  logic         rden = 1'b0;
  logic [31:0]  rdata;
  logic         empty, eof;
  logic         open = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mdl [4][$];
  logic [31:0] last_exp = '0;

  typedef struct {
    int          ch;
    int          n;
    logic [31:0] hdr1;
    logic [31:0] hdr2;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  xillybus_rd_stream_mux #(
    .NUM_CH   (4),
    .DATA_W   (32),
    .FIFO_AW  (4),
    .MAX_BURST(8)
  ) dut (
    .bus_clk     (clk),
    .pcie_perstn (rst_n),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .user_r_rden (rden),
    .user_r_data (rdata),
    .user_r_empty(empty),
    .user_r_eof  (eof),
    .user_r_open (open)
  );

  // Read monitor: an accepted read at an edge presents its word right after that edge.
  logic        rd_acc;
  logic [31:0] rd_exp;
  always @(posedge clk) begin
    rd_acc = rden && !empty && open && rst_n;
    #1;
    if (rd_acc) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_extra: got %h, required no word", rdata);
      end else begin
        rd_exp   = exp_q.pop_front();
        last_exp = rd_exp;
        if (rdata !== rd_exp) begin
          n_bad++;
          $display("FAIL rd_word: got %h, required %h", rdata, rd_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_valid = '0;
    rden     = 1'b0;
    open     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_words(input int ch, input int n, input logic [31:0] base);
    logic ok;
    int   guard;
    for (int k = 0; k < n; k++) begin
      ch_data[ch*32 +: 32] = base + 32'(k);
      ch_valid[ch] = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        ok = ch_ready[ch];
        @(posedge clk);
        #1;
        guard++;
      end while (!ok && guard < 100);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL push_timeout: ch%0d ready stayed %b, required 1", ch, ok);
      end else begin
        mdl[ch].push_back(base + 32'(k));
      end
    end
    ch_valid[ch] = 1'b0;
  endtask

  task automatic exp_burst(input int ch, input int len, input logic [31:0] hdr);
`ifdef XILLY_MUX_CRC_EN
    logic [31:0] sum;
    sum = '0;
`endif
    exp_q.push_back(hdr);
    for (int k = 0; k < len; k++) begin
`ifdef XILLY_MUX_CRC_EN
      sum = sum + mdl[ch][0];
`endif
      exp_q.push_back(mdl[ch].pop_front());
    end
`ifdef XILLY_MUX_CRC_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || !empty) && cyc < 500) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || !empty) begin
      n_bad++;
      $display("FAIL %s_drain: %0d words still expected, empty=%b, required 0 and 1",
               name, exp_q.size(), empty);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ch: 0, n: 1,  hdr1: 32'hA500_0001, hdr2: 32'h0};
    vecs[1] = '{ch: 1, n: 3,  hdr1: 32'hA501_0003, hdr2: 32'h0};
    vecs[2] = '{ch: 2, n: 8,  hdr1: 32'hA502_0008, hdr2: 32'h0};
    vecs[3] = '{ch: 3, n: 10, hdr1: 32'hA503_0008, hdr2: 32'hA503_0002};
    vecs[4] = '{ch: 1, n: 16, hdr1: 32'hA501_0008, hdr2: 32'hA501_0008};

    do_reset();
    check("rst_ready", 32'(ch_ready), 32'hF);
    check("rst_data", rdata, 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_eof", 32'(eof), 32'h0);

    // Three words on ch0, continuous host reads.
    push_words(0, 1, 32'h11);
    push_words(0, 1, 32'h22);
    push_words(0, 1, 32'h33);
    exp_burst(0, 3, 32'hA500_0003);
    rden = 1'b1;
    open = 1'b1;
    wait_drain("basic");

    // Single-channel bursts, including exact MAX_BURST, split bursts and a full FIFO.
    for (int v = 0; v < 5; v++) begin
      open = 1'b0;
      push_words(vecs[v].ch, vecs[v].n, 32'hC000_0000 + 32'(v * 65536));
      exp_burst(vecs[v].ch, (vecs[v].n > 8) ? 8 : vecs[v].n, vecs[v].hdr1);
      if (vecs[v].n > 8) exp_burst(vecs[v].ch, vecs[v].n - 8, vecs[v].hdr2);
      @(posedge clk);
      #1 open = 1'b1;
      wait_drain($sformatf("vec%0d", v));
    end

    // Round robin across four preloaded channels.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        ch_data[c*32 +: 32] = 32'h2000_0000 + 32'(c * 256 + k);
        mdl[c].push_back(32'h2000_0000 + 32'(c * 256 + k));
      end
      ch_valid = 4'hF;
      @(posedge clk);
      #1;
    end
    ch_valid = '0;
    for (int c = 0; c < 4; c++) exp_burst(c, 8, 32'hA500_0008 | 32'(c << 16));
    for (int c = 0; c < 4; c++) exp_burst(c, 2, 32'hA500_0002 | 32'(c << 16));
    rden = 1'b1;
    open = 1'b1;
    wait_drain("rr");

    // Reads while empty are ignored and the last word holds.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("empty_rd_data", rdata, last_exp);
      check("empty_rd_flag", 32'(empty), 32'h1);
    end
    push_words(3, 1, 32'h5555_0001);
    exp_burst(3, 1, 32'hA503_0001);
    wait_drain("after_empty_rd");

    // Host back-pressure: stall with the output FIFO full, channel FIFO filling up.
    rden = 1'b0;
    open = 1'b0;
    push_words(1, 16, 32'h3000_0000);
    check("full_ready", 32'(ch_ready[1]), 32'h0);
    @(posedge clk);
    #1 open = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stall_empty", 32'(empty), 32'h0);
    push_words(1, 3, 32'h3000_0010);
    check("stall_ready", 32'(ch_ready[1]), 32'h0);
    exp_burst(1, 8, 32'hA501_0008);
    exp_burst(1, 8, 32'hA501_0008);
    exp_burst(1, 3, 32'hA501_0003);
    rden = 1'b1;
    wait_drain("stall");

    // Close after header + 2 of 5 payload words; reopen resends the remaining 3.
    rden = 1'b0;
    open = 1'b0;
    push_words(2, 5, 32'h4000_0000);
    @(posedge clk);
    #1 open = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_pre_empty", 32'(empty), 32'h0);
    open = 1'b0;
    @(posedge clk);
    #1;
    check("abort_empty", 32'(empty), 32'h1);
    void'(mdl[2].pop_front());
    void'(mdl[2].pop_front());
    exp_burst(2, 3, 32'hA502_0003);
    open = 1'b1;
    rden = 1'b1;
    wait_drain("abort");

    // Payload whose sum wraps; a trailer word follows when the option is built in.
    open = 1'b0;
    push_words(0, 1, 32'hFFFF_FFFF);
    push_words(0, 1, 32'h0000_0002);
    exp_burst(0, 2, 32'hA500_0002);
    @(posedge clk);
    #1 open = 1'b1;
    wait_drain("trailer");

    // Reset asserted mid-burst takes effect without a clock edge.
    rden = 1'b0;
    open = 1'b0;
    push_words(2, 5, 32'h6000_0000);
    open = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty), 32'h1);
    check("mid_rst_ready", 32'(ch_ready), 32'hF);
    check("mid_rst_data", rdata, 32'h0);
    mdl[2].delete();
    open = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_empty", 32'(empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
